// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: opcodes, ALU op
// encodings, instruction field positions and the ID/EX control bundle.
package pipe_pkg;

    localparam int XLEN      = 16;
    localparam int IADDR_W   = 8;
    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;

    typedef enum logic [3:0] {
        OP_RALU = 4'd0,
        OP_ADDI = 4'd1,
        OP_LW   = 4'd2,
        OP_SW   = 4'd3,
        OP_BEQ  = 4'd4,
        OP_BNE  = 4'd5,
        OP_J    = 4'd6,
        OP_HALT = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } aluop_e;

    // Field positions (R: op rd rs rt funct, I: op rt rs imm6, J: op addr)
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS_MSB    = 8;
    localparam int RS_LSB    = 6;
    localparam int RT_R_MSB  = 5;
    localparam int RT_R_LSB  = 3;
    localparam int RT_I_MSB  = 11;
    localparam int RT_I_LSB  = 9;
    localparam int FUNCT_MSB = 2;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 5;
    localparam int IMM_LSB   = 0;
    localparam int JADDR_MSB = 7;
    localparam int JADDR_LSB = 0;

    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   alu_src;
        aluop_e alu_op;
    } idex_ctrl_t;

    // True when the opcode reads its rs field as a register operand
    function automatic logic op_uses_rs(input logic [3:0] op);
        return (op == OP_RALU) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)   || (op == OP_BEQ)  || (op == OP_BNE);
    endfunction

    // True when the opcode reads its rt field as a register operand
    function automatic logic op_uses_rt(input logic [3:0] op);
        return (op == OP_RALU) || (op == OP_SW) ||
               (op == OP_BEQ)  || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 8 x 16 register file: two asynchronous read ports with write-first
// bypass, one synchronous write port, r0 hardwired to zero.
module id_regfile
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_COUNT  = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [2:0]            waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [2:0]            raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [2:0]            raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

    // Next register contents: one write per cycle, writes to r0 dropped
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != 3'd0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Register storage, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a_o = (raddr_a_i == 3'd0)                  ? '0 :
                       (we_i && (raddr_a_i == waddr_i))      ? wdata_i :
                                                               regs_q[raddr_a_i];

    assign rdata_b_o = (raddr_b_i == 3'd0)                  ? '0 :
                       (we_i && (raddr_b_i == waddr_i))      ? wdata_i :
                                                               regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decode, register read, hazard detection,
// branch/jump resolution, wrong-path squash and the ID/EX register.
module id_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = IADDR_W,
    parameter int REG_COUNT  = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic [15:0]           instr_i,
    input  logic [ADDR_WIDTH-1:0] pcplus1_i,
    input  logic                  wb_we_i,
    input  logic [2:0]            wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  regWrite_E_i,
    input  logic                  memRead_E_i,
    input  logic [2:0]            dest_E_i,
    input  logic                  regWrite_M_i,
    input  logic                  memRead_M_i,
    input  logic [2:0]            dest_M_i,
    input  logic [DATA_WIDTH-1:0] alu_M_i,
    output logic                  PC_src_o,
    output logic [ADDR_WIDTH-1:0] branchAddr_o,
    output logic                  jump_o,
    output logic [ADDR_WIDTH-1:0] jumpAddr_o,
    output logic                  stallPC_o,
    output logic                  stallIF_ID_o,
    output logic                  flushIF_ID_o,
    output logic                  stop_o,
    output logic                  idex_regWrite_o,
    output logic                  idex_memRead_o,
    output logic                  idex_memWrite_o,
    output logic                  idex_aluSrc_o,
    output logic [2:0]            idex_aluOp_o,
    output logic [DATA_WIDTH-1:0] idex_rsData_o,
    output logic [DATA_WIDTH-1:0] idex_rtData_o,
    output logic [DATA_WIDTH-1:0] idex_imm_o,
    output logic [2:0]            idex_rs_o,
    output logic [2:0]            idex_rt_o,
    output logic [2:0]            idex_dest_o,
    output logic [ADDR_WIDTH-1:0] idex_pc_o
);

    // Decode results
    logic                  live;
    logic [3:0]            opcode;
    logic                  op_r, op_addi, op_lw, op_sw;
    logic                  op_beq, op_bne, op_j, op_halt, is_branch;
    logic                  uses_rs, uses_rt;
    logic [2:0]            rs_idx, rt_idx, dest_idx;
    logic [DATA_WIDTH-1:0] imm_ext;

    // Register file read data
    logic [DATA_WIDTH-1:0] rs_rf, rt_rf;

    // Hazard and control-flow results
    logic                  rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic                  load_use, branch_ex, branch_mem_load, stall;
    logic                  fwd_m_ok;
    logic [DATA_WIDTH-1:0] rs_cmp, rt_cmp;
    logic                  taken, jump, halt, flush;

    // Squash flag and ID/EX register
    logic                  flush_q, flush_d;
    idex_ctrl_t            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
    logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [2:0]            rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  issue;

    id_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (rs_idx),
        .rdata_a_o (rs_rf),
        .raddr_b_i (rt_idx),
        .rdata_b_o (rt_rf)
    );

    // Decode; a squashed slot or a stopped processor decodes as NOP
    always_comb begin
        live      = run_i && !flush_q;
        opcode    = instr_i[OP_MSB:OP_LSB];
        op_r      = live && (opcode == OP_RALU);
        op_addi   = live && (opcode == OP_ADDI);
        op_lw     = live && (opcode == OP_LW);
        op_sw     = live && (opcode == OP_SW);
        op_beq    = live && (opcode == OP_BEQ);
        op_bne    = live && (opcode == OP_BNE);
        op_j      = live && (opcode == OP_J);
        op_halt   = live && (opcode == OP_HALT);
        is_branch = op_beq || op_bne;
        uses_rs   = live && op_uses_rs(opcode);
        uses_rt   = live && op_uses_rt(opcode);
        rs_idx    = instr_i[RS_MSB:RS_LSB];
        rt_idx    = (opcode == OP_RALU) ? instr_i[RT_R_MSB:RT_R_LSB]
                                        : instr_i[RT_I_MSB:RT_I_LSB];
        dest_idx  = (op_r || op_addi || op_lw) ? instr_i[RD_MSB:RD_LSB] : 3'd0;
        imm_ext   = {{(DATA_WIDTH-6){instr_i[IMM_MSB]}}, instr_i[IMM_MSB:IMM_LSB]};
    end

    // Hazard detection against the instructions in EX and MEM
    always_comb begin
        rs_hit_e        = uses_rs && (rs_idx != 3'd0) && (rs_idx == dest_E_i);
        rt_hit_e        = uses_rt && (rt_idx != 3'd0) && (rt_idx == dest_E_i);
        rs_hit_m        = uses_rs && (rs_idx != 3'd0) && (rs_idx == dest_M_i);
        rt_hit_m        = uses_rt && (rt_idx != 3'd0) && (rt_idx == dest_M_i);
        load_use        = memRead_E_i && (rs_hit_e || rt_hit_e);
        branch_ex       = is_branch && regWrite_E_i && (rs_hit_e || rt_hit_e);
        branch_mem_load = is_branch && memRead_M_i && (rs_hit_m || rt_hit_m);
        stall           = load_use || branch_ex || branch_mem_load;
    end

    // Branch compare with MEM-stage ALU forwarding, then redirect decisions
    always_comb begin
        fwd_m_ok = regWrite_M_i && !memRead_M_i;
        rs_cmp   = (fwd_m_ok && (rs_idx != 3'd0) && (rs_idx == dest_M_i)) ? alu_M_i : rs_rf;
        rt_cmp   = (fwd_m_ok && (rt_idx != 3'd0) && (rt_idx == dest_M_i)) ? alu_M_i : rt_rf;
        taken    = !stall && ((op_beq && (rs_cmp == rt_cmp)) ||
                              (op_bne && (rs_cmp != rt_cmp)));
        jump     = !stall && op_j;
        halt     = !stall && op_halt;
        flush    = taken || jump || halt;
        flush_d  = flush && !stall;
    end

    assign PC_src_o     = taken;
    assign branchAddr_o = pcplus1_i + imm_ext[ADDR_WIDTH-1:0];
    assign jump_o       = jump;
    assign jumpAddr_o   = instr_i[JADDR_MSB:JADDR_LSB];
    assign stallPC_o    = stall;
    assign stallIF_ID_o = stall;
    assign flushIF_ID_o = flush;
    assign stop_o       = halt;

    // ID/EX next value; branches, jumps and HALT finish in ID and issue as bubbles
    always_comb begin
        issue     = !stall && (op_r || op_addi || op_lw || op_sw);
        ctrl_d    = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = 3'd0;
        rt_d      = 3'd0;
        dest_d    = 3'd0;
        pc_d      = '0;
        if (issue) begin
            ctrl_d.reg_write = op_r || op_addi || op_lw;
            ctrl_d.mem_read  = op_lw;
            ctrl_d.mem_write = op_sw;
            ctrl_d.alu_src   = op_addi || op_lw || op_sw;
            ctrl_d.alu_op    = op_r ? aluop_e'(instr_i[FUNCT_MSB:FUNCT_LSB]) : ALU_ADD;
            rs_data_d        = rs_rf;
            rt_data_d        = uses_rt ? rt_rf : '0;
            imm_d            = imm_ext;
            rs_d             = rs_idx;
            rt_d             = uses_rt ? rt_idx : 3'd0;
            dest_d           = dest_idx;
            pc_d             = pcplus1_i;
        end
    end

    // Squash flag and ID/EX register, both cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= 3'd0;
            rt_q      <= 3'd0;
            dest_q    <= 3'd0;
            pc_q      <= '0;
        end else begin
            flush_q   <= flush_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dest_q    <= dest_d;
            pc_q      <= pc_d;
        end
    end

    assign idex_regWrite_o = ctrl_q.reg_write;
    assign idex_memRead_o  = ctrl_q.mem_read;
    assign idex_memWrite_o = ctrl_q.mem_write;
    assign idex_aluSrc_o   = ctrl_q.alu_src;
    assign idex_aluOp_o    = ctrl_q.alu_op;
    assign idex_rsData_o   = rs_data_q;
    assign idex_rtData_o   = rt_data_q;
    assign idex_imm_o      = imm_q;
    assign idex_rs_o       = rs_q;
    assign idex_rt_o       = rt_q;
    assign idex_dest_o     = dest_q;
    assign idex_pc_o       = pc_q;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 16-bit five-stage pipeline, directly downstream of the fetch stage. It consumes the fetched instruction and the IF/ID PC+1 value, reads the register file, and resolves branches and jumps in ID. It drives the fetch stage's redirect, stall, flush and stop controls, and it registers the decoded operation into the ID/EX pipeline register.

## Interface
- DATA_WIDTH, 16, register and immediate width
- ADDR_WIDTH, 8, instruction address width
- REG_COUNT, 8, architectural registers; r0 reads 0 and ignores writes
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- run_i  in  1  processor status from fetch; 0 forces bubbles and suppresses all redirects
- instr_i  in  16  IM read data, aligned with pcplus1_i
- pcplus1_i  in  8  IF/ID PC+1
- wb_we_i / wb_addr_i / wb_data_i  in  1/3/16  writeback port
- regWrite_E_i, memRead_E_i, dest_E_i  in  1,1,3  instruction currently in EX
- regWrite_M_i, memRead_M_i, dest_M_i, alu_M_i  in  1,1,3,16  instruction currently in MEM
- PC_src_o, branchAddr_o  out  1, 8  taken-branch redirect
- jump_o, jumpAddr_o  out  1, 8  jump redirect
- stallPC_o, stallIF_ID_o, flushIF_ID_o  out  1  fetch controls
- stop_o  out  1  HALT pulse, clears fetch run status
- idex_regWrite_o, idex_memRead_o, idex_memWrite_o, idex_aluSrc_o  out  1 each  ID/EX control
- idex_aluOp_o  out  3  ALU op
- idex_rsData_o, idex_rtData_o, idex_imm_o  out  16 each  operands and sign-extended immediate
- idex_rs_o, idex_rt_o, idex_dest_o  out  3 each  register indices for EX forwarding
- idex_pc_o  out  8  PC+1 of the issued instruction

## Operation
- Formats: R = op[15:12] rd[11:9] rs[8:6] rt[5:3] funct[2:0]; I = op rt[11:9] rs[8:6] imm6[5:0]; J = op addr[7:0].
- Opcodes: 0 R-ALU (aluOp = funct: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL), 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 7 HALT. Opcodes 8–15 decode as NOP (all controls 0).
- ADDI, LW and SW use aluOp ADD and aluSrc=1. dest is rd for R-type and rt for ADDI/LW.
- Operand use: rs is used by R, ADDI, LW, SW, BEQ, BNE. rt is used by R, SW, BEQ, BNE.
- Register file read is write-first: a read of wb_addr_i in the same cycle as wb_we_i returns wb_data_i.
- Squash flag flush_q: set on the clock edge where flushIF_ID_o=1 and stall=0. While flush_q=1, instr_i is treated as NOP, so no redirect, stall or stop is produced.
- Stall (stall=1 drives stallPC_o and stallIF_ID_o, and a bubble into ID/EX) when any of the following holds:
  - Load-use: memRead_E_i and dest_E_i equals a used nonzero source.
  - Branch on EX result: BEQ/BNE and regWrite_E_i and dest_E_i equals a used nonzero source.
  - Branch on a load in MEM: BEQ/BNE and memRead_M_i and dest_M_i equals a used nonzero source.
- Branch compare forwarding: use alu_M_i when regWrite_M_i and !memRead_M_i and dest_M_i equals the source (nonzero). Otherwise use the register file read value.
- Branch taken: BEQ with equal operands or BNE with unequal operands, and stall=0. Then:
  - PC_src_o=1
  - branchAddr_o = pcplus1_i + sext(imm6), truncated to 8 bits (wraps)
  - flushIF_ID_o=1
- J with stall=0: jump_o=1, jumpAddr_o = addr, flushIF_ID_o=1.
- HALT with stall=0: stop_o=1 and flushIF_ID_o=1. HALT issues as a bubble.
- run_i=0: all redirect, stall, flush and stop outputs are 0, and ID/EX loads a bubble.

## Timing
- All redirect, stall, flush and stop outputs are combinational from the current ID contents; fetch samples them on the next edge.
- ID/EX updates every edge. A bubble zeroes all control bits and idex_dest_o; the data fields are don't-care but are zeroed.
- rst: every ID/EX output is 0 and flush_q=0 on the following edge. rst overrides run_i and stall mid-operation.
- Taken branch or jump: redirect takes effect next cycle. Exactly one wrong-path instruction is squashed: IF/ID is flushed, and flush_q covers the aligned instr_i.
- A load-use stall lasts 1 cycle. A branch depending on a load in EX stalls 2 cycles. A branch depending on an ALU result in EX stalls 1 cycle.
- Simultaneous events: a stall suppresses any same-cycle redirect. wb_we_i to r0 is ignored.

## Structure
- pipe_pkg holds the opcode constants, the aluOp encodings, the instruction field position constants and an ID/EX control struct; these are shared with the EX stage.
- The sub-module id_regfile provides the 8×16 register file: two asynchronous read ports, one synchronous write port, write-first bypass, and r0 hardwired to 0.
- id_stage itself contains decode, hazard detection, branch compare, flush_q and the ID/EX register.

## Test plan
- ADDI r1,r0,5 followed by ADD r2,r1,r1 with writeback completing: after the EX/MEM/WB forwarding path, r2=10. ID/EX shows aluOp 0, dest 2, no stalls.
- LW r3,0(r0) in EX while ADD r4,r3,r3 is in ID: stallPC_o and stallIF_ID_o are high for exactly 1 cycle and one bubble enters ID/EX; on the next cycle the ADD issues.
- BEQ r1,r1,-2 at pcplus1=0x10: PC_src_o=1, branchAddr_o=0x0E, flushIF_ID_o=1; the next instr_i is squashed to NOP.
- BNE at pcplus1=0xFF with imm=+3: branchAddr_o=0x02, showing the 8-bit wrap.
- J 0x40 immediately followed by HALT on the wrong path: jump_o=1 with jumpAddr_o=0x40; the squashed HALT never asserts stop_o. A HALT at the target asserts stop_o for 1 cycle.
- rst asserted during a 2-cycle load-branch stall: on the next cycle all ID/EX outputs are 0 and no redirect is asserted.
